// File: rtl/func_ctrl_pkg.sv
// Shared types and constants for the function-bank sweep controller.
// Holds the FSM state encoding and the bank's select/table widths.
package func_ctrl_pkg;

    localparam int FLAG_W   = 5;
    localparam int TABLE_W  = 16;
    localparam int IDX_W    = 4;
    localparam int SETTLE_W = 3;

    localparam logic [FLAG_W-1:0] IDLE_FLAG_DEFAULT = 5'b00000;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        RESP
    } state_t;

endpackage

// File: rtl/func_sweep_ctrl.sv
// Sweeps all 16 {A,B,C,D} combinations through one flag-selected bank function
// and returns the sampled truth table on a valid/ready response port.
module func_sweep_ctrl
    import func_ctrl_pkg::*;
#(
    parameter logic [FLAG_W-1:0] IDLE_FLAG = IDLE_FLAG_DEFAULT,
    parameter int unsigned       SETTLE    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [FLAG_W-1:0]  req_flag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [TABLE_W-1:0] rsp_table,
    output logic               rsp_err,
    output logic [FLAG_W-1:0]  flag,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               D,
    input  logic               Y
);

    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(TABLE_W - 1);

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                accept;
    logic                sample;
    logic                y_one;
    logic                y_bad;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        sample    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                sample = !(settle_cnt < SETTLE_MAX);
                if (sample && idx == IDX_LAST) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A floating or contended bus reads as z/x; record it as 0 and flag it.
    assign y_one = (Y === 1'b1);
    assign y_bad = (Y !== 1'b0) && (Y !== 1'b1);

    // NOTE: only a handful of control/result registers exist here and all of
    // them are reset; there is no storage array that would need skipping.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag       <= IDLE_FLAG;
            idx        <= '0;
            settle_cnt <= '0;
            rsp_table  <= '0;
            rsp_err    <= 1'b0;
        end else if (accept) begin
            flag       <= req_flag;
            idx        <= '0;
            settle_cnt <= '0;
            rsp_table  <= '0;
            rsp_err    <= 1'b0;
        end else if (state == SWEEP) begin
            if (!sample) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt     <= '0;
                rsp_table[idx] <= y_one;
                if (y_bad) rsp_err <= 1'b1;
                // Releasing the bank on the last sample parks it before RESP.
                if (idx == IDX_LAST) begin
                    idx  <= '0;
                    flag <= IDLE_FLAG;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign {A, B, C, D} = idx;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Bench for func_sweep_ctrl: two controllers (SETTLE 0 and 2) each wired to a
// behavioural function bank, checked against a truth-table reference model.
module tb_func_sweep_ctrl;

    localparam logic [4:0]  IDLE_CODE  = 5'b00000;
    localparam logic [4:0]  FN_CODE    = 5'b11001;
    localparam logic [15:0] FN_TABLE   = 16'h0AB7;
    localparam logic [4:0]  FLOAT_CODE = 5'b00111;
    localparam int          SETTLE0    = 0;
    localparam int          SETTLE1    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [4:0]  req_flag  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_table [2];
    logic        rsp_err   [2];
    logic [4:0]  flag      [2];
    logic        a [2];
    logic        b [2];
    logic        c [2];
    logic        d [2];
    wire         y0;
    wire         y1;

    logic [15:0] bank_tt [32];
    logic        bank_en [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // The bank: a decoded code drives its truth-table bit, anything else floats.
    assign y0 = bank_en[flag[0]] ? bank_tt[flag[0]][{a[0], b[0], c[0], d[0]}] : 1'bz;
    assign y1 = bank_en[flag[1]] ? bank_tt[flag[1]][{a[1], b[1], c[1], d[1]}] : 1'bz;

    func_sweep_ctrl #(.IDLE_FLAG(IDLE_CODE), .SETTLE(SETTLE0)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_flag(req_flag[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_table(rsp_table[0]), .rsp_err(rsp_err[0]),
        .flag(flag[0]), .A(a[0]), .B(b[0]), .C(c[0]), .D(d[0]), .Y(y0)
    );

    func_sweep_ctrl #(.IDLE_FLAG(IDLE_CODE), .SETTLE(SETTLE1)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_flag(req_flag[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_table(rsp_table[1]), .rsp_err(rsp_err[1]),
        .flag(flag[1]), .A(a[1]), .B(b[1]), .C(c[1]), .D(d[1]), .Y(y1)
    );

    function automatic int settle_of(input int u);
        return (u == 0) ? SETTLE0 : SETTLE1;
    endfunction

    function automatic logic [3:0] abcd(input int u);
        return {a[u], b[u], c[u], d[u]};
    endfunction

    // Reference: evaluate the bank for every index; non-0/1 reads give 0 + error.
    function automatic void model(input logic [4:0] code, output logic [15:0] tt,
                                  output logic err);
        logic v;
        tt  = '0;
        err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = bank_en[code] ? bank_tt[code][i] : 1'bz;
            if (v === 1'b1)      tt[i] = 1'b1;
            else if (v !== 1'b0) err   = 1'b1;
        end
    endfunction

    // One full request/response; stall = cycles rsp_ready stays low after rsp_valid.
    task automatic run_req(input int u, input logic [4:0] code, input int stall,
                           input bit hold_next, input string tag);
        logic [15:0] exp_tt;
        logic        exp_err;
        int          s;
        int          n;
        int          lat;
        bit          hold_ok;
        bit          stable;
        s = settle_of(u);
        model(code, exp_tt, exp_err);
        @(negedge clk);
        req_flag[u]  = code;
        req_valid[u] = 1'b1;
        n = 0;
        while (req_ready[u] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (req_ready[u] !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: req_ready=%b want 1 within 100 cycles", tag, req_ready[u]);
            req_valid[u] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[u] = hold_next;
        hold_ok = 1'b1;
        lat     = -1;
        for (int k = 0; k < 200; k++) begin
            if (rsp_valid[u] === 1'b1) begin
                lat = k;
                break;
            end
            if (abcd(u) !== 4'(k / (s + 1)) || flag[u] !== code || req_ready[u] !== 1'b0)
                hold_ok = 1'b0;
            @(negedge clk);
        end
        total++;
        if (lat != 16 * (s + 1)) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, 16 * (s + 1));
        end
        if (lat < 0) begin
            req_valid[u] = 1'b0;
            return;
        end
        total++;
        if (!hold_ok) begin
            bad++;
            $display("FAIL %s sweep_hold: inputs/flag not held %0d cycles per index", tag, s + 1);
        end
        total++;
        if (rsp_table[u] !== exp_tt) begin
            bad++;
            $display("FAIL %s table: got %h want %h", tag, rsp_table[u], exp_tt);
        end
        total++;
        if (rsp_err[u] !== exp_err) begin
            bad++;
            $display("FAIL %s err: got %b want %b", tag, rsp_err[u], exp_err);
        end
        total++;
        if (flag[u] !== IDLE_CODE || abcd(u) !== 4'h0 || req_ready[u] !== 1'b0) begin
            bad++;
            $display("FAIL %s resp_release: flag=%h abcd=%h req_ready=%b want %h 0 0",
                     tag, flag[u], abcd(u), req_ready[u], IDLE_CODE);
        end
        stable = 1'b1;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (rsp_valid[u] !== 1'b1 || rsp_table[u] !== exp_tt || rsp_err[u] !== exp_err ||
                req_ready[u] !== 1'b0 || flag[u] !== IDLE_CODE)
                stable = 1'b0;
        end
        if (stall > 0) begin
            total++;
            if (!stable) begin
                bad++;
                $display("FAIL %s resp_stall: response changed or req_ready rose during %0d-cycle stall",
                         tag, stall);
            end
        end
        rsp_ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[u] = 1'b0;
        total++;
        if (rsp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
            bad++;
            $display("FAIL %s consume: rsp_valid=%b req_ready=%b want 0 1",
                     tag, rsp_valid[u], req_ready[u]);
        end
        req_valid[u] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            total++;
            if (req_ready[u] !== 1'b1 || rsp_valid[u] !== 1'b0 || rsp_table[u] !== 16'h0000 ||
                rsp_err[u] !== 1'b0 || flag[u] !== IDLE_CODE || abcd(u) !== 4'h0) begin
                bad++;
                $display("FAIL reset_values u%0d: rdy=%b vld=%b tbl=%h err=%b flag=%h abcd=%h",
                         u, req_ready[u], rsp_valid[u], rsp_table[u], rsp_err[u], flag[u], abcd(u));
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_req(0, FN_CODE, 0, 1'b0, "fn_settle0");
        run_req(1, FN_CODE, 0, 1'b0, "fn_settle2");
    endtask

    task automatic test_float();
        run_req(0, FLOAT_CODE, 0, 1'b0, "float");
        run_req(1, IDLE_CODE, 1, 1'b0, "idle_code");
    endtask

    task automatic test_stall();
        run_req(0, FN_CODE, 10, 1'b1, "stall10");
    endtask

    task automatic test_reset_mid(input int u);
        int n;
        @(negedge clk);
        req_flag[u]  = FN_CODE;
        req_valid[u] = 1'b1;
        n = 0;
        while (req_ready[u] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[u] = 1'b0;
        n = 0;
        while (abcd(u) !== 4'd7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (abcd(u) !== 4'd7) begin
            bad++;
            $display("FAIL reset_mid_reach u%0d: abcd=%h want 7", u, abcd(u));
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (flag[u] !== IDLE_CODE || abcd(u) !== 4'h0 || rsp_valid[u] !== 1'b0 ||
            req_ready[u] !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid u%0d: flag=%h abcd=%h vld=%b rdy=%b want %h 0 0 1",
                     u, flag[u], abcd(u), rsp_valid[u], req_ready[u], IDLE_CODE);
        end
        n = 0;
        for (int k = 0; k < 40 * (settle_of(u) + 1); k++) begin
            @(negedge clk);
            if (rsp_valid[u] !== 1'b0) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL reset_discard u%0d: rsp_valid high %0d cycles want 0", u, n);
        end
        run_req(u, FN_CODE, 0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back(input int u);
        logic [15:0] exp_tt;
        logic        exp_err;
        logic [15:0] got_tt;
        int          s;
        int          n;
        int          first_rv;
        int          acc2;
        int          rv2;
        s = settle_of(u);
        model(FN_CODE, exp_tt, exp_err);
        got_tt = 'x;
        @(negedge clk);
        rsp_ready[u] = 1'b1;
        req_flag[u]  = FN_CODE;
        req_valid[u] = 1'b1;
        n = 0;
        while (req_ready[u] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        first_rv = -1;
        acc2     = -1;
        rv2      = -1;
        for (int k = 0; k < 400 && rv2 < 0; k++) begin
            if (first_rv < 0 && rsp_valid[u] === 1'b1) begin
                first_rv = k;
            end else if (first_rv >= 0 && acc2 < 0 && req_ready[u] === 1'b1) begin
                acc2 = k + 1;
            end else if (acc2 >= 0) begin
                req_valid[u] = 1'b0;
                if (rsp_valid[u] === 1'b1) begin
                    rv2    = k;
                    got_tt = rsp_table[u];
                end
            end
            if (rv2 < 0) @(negedge clk);
        end
        req_valid[u] = 1'b0;
        total++;
        if (first_rv != 16 * (s + 1)) begin
            bad++;
            $display("FAIL b2b_first u%0d: rsp_valid at %0d want %0d", u, first_rv, 16 * (s + 1));
        end
        total++;
        if (first_rv < 0 || acc2 != first_rv + 2) begin
            bad++;
            $display("FAIL b2b_accept u%0d: second accept at %0d want %0d", u, acc2, first_rv + 2);
        end
        total++;
        if (acc2 < 0 || rv2 != acc2 + 16 * (s + 1) || got_tt !== exp_tt) begin
            bad++;
            $display("FAIL b2b_second u%0d: rsp at %0d table %h want at %0d table %h",
                     u, rv2, got_tt, acc2 + 16 * (s + 1), exp_tt);
        end
        @(posedge clk);
        @(negedge clk);
        rsp_ready[u] = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_drain u%0d: rsp_valid=%b req_ready=%b want 0 1",
                     u, rsp_valid[u], req_ready[u]);
        end
    endtask

    task automatic test_random();
        logic [4:0] pool [7];
        logic [4:0] code;
        int         u;
        pool = '{FN_CODE, 5'd1, 5'd2, 5'd3, 5'd4, FLOAT_CODE, IDLE_CODE};
        for (int it = 0; it < 10; it++) begin
            u = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) code = 5'($urandom);
            else                           code = pool[$urandom_range(0, 6)];
            run_req(u, code, int'($urandom_range(0, 3)), 1'b0, $sformatf("rand%0d", it));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            bank_en[i] = 1'b0;
            bank_tt[i] = 16'h0000;
        end
        bank_en[FN_CODE] = 1'b1;
        bank_tt[FN_CODE] = FN_TABLE;
        for (int i = 1; i <= 4; i++) begin
            bank_en[i] = 1'b1;
            bank_tt[i] = 16'($urandom);
        end
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            req_flag[u]  = 5'd0;
            rsp_ready[u] = 1'b0;
        end
        reset = 1'b1;

        test_reset();
        test_basic();
        test_float();
        test_stall();
        test_reset_mid(0);
        test_reset_mid(1);
        test_back_to_back(0);
        test_back_to_back(1);
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
